// File: rtl/imem_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational IMEM and
// buffers {PC, instruction} pairs in a 2-entry FIFO for the decode stage.
module imem_fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  queue_count,
  output logic [15:0] fetched_count
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {ST_FETCH, ST_HALT, ST_FAULT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] q1_pc;
  logic [31:0] q1_instr;
  logic [31:0] target_pc;
  logic        redirect_eff;
  logic        pc_legal;
  logic        target_legal;
  logic        halt_word;
  logic        pop;
  logic        push;

  assign address = pc;

  // Redirect is dead once faulted, so it neither flushes nor blocks pops there.
  always_comb begin
    redirect_eff = redirect && (state != ST_FAULT);
    target_pc    = {redirect_target[31:2], 2'b00};
    pc_legal     = pc < PC_LIMIT;
    target_legal = target_pc < PC_LIMIT;
    halt_word    = ((instruction[31:26] == 6'b000100) || (instruction[31:26] == 6'b000101))
                   && (instruction[15:0] == 16'hFFFF);
    pop          = fetch_valid && fetch_ready && !redirect_eff;
    push         = (state == ST_FETCH) && enable && !redirect_eff && pc_legal
                   && ((queue_count != 2'd2) || pop);
  end

  always_comb begin
    state_next = state;
    if (redirect_eff)
      state_next = target_legal ? ST_FETCH : ST_FAULT;
    else if ((state == ST_FETCH) && enable && !pc_legal)
      state_next = ST_FAULT;
    else if (push && halt_word)
      state_next = ST_HALT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_FETCH;
      pc            <= RESET_PC;
      halted        <= 1'b0;
      fault         <= 1'b0;
      fetched_count <= 16'h0000;
    end else begin
      state  <= state_next;
      halted <= (state_next == ST_HALT);
      fault  <= (state_next == ST_FAULT);
      if (redirect_eff)
        pc <= target_pc;
      else if (push)
        pc <= pc + 32'd4;
      if (push && (fetched_count != 16'hFFFF))
        fetched_count <= fetched_count + 16'd1;
    end
  end

  // Head lives in the output registers; the second entry sits behind it in q1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_instr <= 32'h0;
      fetch_pc    <= 32'h0;
      q1_pc       <= 32'h0;
      q1_instr    <= 32'h0;
      queue_count <= 2'd0;
    end else if (redirect_eff) begin
      fetch_valid <= 1'b0;
      queue_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (queue_count == 2'd0) begin
            fetch_pc    <= pc;
            fetch_instr <= instruction;
            fetch_valid <= 1'b1;
          end else begin
            q1_pc    <= pc;
            q1_instr <= instruction;
          end
          queue_count <= queue_count + 2'd1;
        end
        2'b01: begin
          fetch_pc    <= q1_pc;
          fetch_instr <= q1_instr;
          fetch_valid <= (queue_count == 2'd2);
          queue_count <= queue_count - 2'd1;
        end
        2'b11: begin
          if (queue_count == 2'd1) begin
            fetch_pc    <= pc;
            fetch_instr <= instruction;
          end else begin
            fetch_pc    <= q1_pc;
            fetch_instr <= q1_instr;
            q1_pc       <= pc;
            q1_instr    <= instruction;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller: streaming, stall, redirect flush,
// branch-to-self halt, range fault and asynchronous reset.
module tb_imem_fetch_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halted;
  logic        fault;
  logic [1:0]  queue_count;
  logic [15:0] fetched_count;

  logic [31:0] imem [128];
  int testsRun  = 0;
  int failCount = 0;

  imem_fetch_controller dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .address         (address),
    .instruction     (instruction),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .fetch_instr     (fetch_instr),
    .fetch_pc        (fetch_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halted          (halted),
    .fault           (fault),
    .queue_count     (queue_count),
    .fetched_count   (fetched_count)
  );

  always #5 clock = ~clock;

  // Combinational IMEM; out-of-range addresses read as zero.
  always_comb begin
    instruction = 32'h0;
    if (address < 32'd512) instruction = imem[address[8:2]];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic redir, input logic [31:0] tgt);
    enable          = en;
    fetch_ready     = rdy;
    redirect        = redir;
    redirect_target = tgt;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = i * 4;
    imem[38] = 32'h1412FFFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Streaming after reset
    doReset();
    checkOutput("rst_valid", 32'(fetch_valid), 32'h0);
    checkOutput("rst_pc", fetch_pc, 32'h0);
    checkOutput("rst_instr", fetch_instr, 32'h0);
    checkOutput("rst_count", 32'(queue_count), 32'h0);
    checkOutput("rst_addr", address, 32'h0);
    checkOutput("rst_fc", 32'(fetched_count), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("stream_valid", 32'(fetch_valid), 32'h1);
      checkOutput("stream_pc", fetch_pc, 32'((k - 1) * 4));
      checkOutput("stream_instr", fetch_instr, 32'((k - 1) * 4));
      checkOutput("stream_count", 32'(queue_count), 32'h1);
      checkOutput("stream_fc", 32'(fetched_count), 32'(k));
      checkOutput("stream_addr", address, 32'(k * 4));
    end
    // Enable low: head drains, PC holds
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("en0_valid", 32'(fetch_valid), 32'h0);
    checkOutput("en0_addr", address, 32'h14);
    checkOutput("en0_fc", 32'(fetched_count), 32'h5);
    tick();
    checkOutput("en0_hold_addr", address, 32'h14);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("en1_pc", fetch_pc, 32'h14);

    // Stall then release
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    doReset();
    for (int k = 1; k <= 5; k++) tick();
    checkOutput("stall_count", 32'(queue_count), 32'h2);
    checkOutput("stall_addr", address, 32'h8);
    checkOutput("stall_head", fetch_pc, 32'h0);
    checkOutput("stall_fc", 32'(fetched_count), 32'h2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("release_pc", fetch_pc, 32'(k * 4));
      checkOutput("release_instr", fetch_instr, 32'(k * 4));
      checkOutput("release_count", 32'(queue_count), 32'h2);
    end

    // Redirect flush with a full queue
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    doReset();
    tick();
    tick();
    checkOutput("pre_redir_count", 32'(queue_count), 32'h2);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0029);
    tick();
    checkOutput("redir_count", 32'(queue_count), 32'h0);
    checkOutput("redir_valid", 32'(fetch_valid), 32'h0);
    checkOutput("redir_addr", address, 32'h28);
    checkOutput("redir_fc", 32'(fetched_count), 32'h2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("redir_first_pc", fetch_pc, 32'h28);
    checkOutput("redir_first_instr", fetch_instr, 32'h28);
    checkOutput("redir_first_fc", 32'(fetched_count), 32'h3);
    tick();
    checkOutput("redir_second_pc", fetch_pc, 32'h2C);

    // Branch-to-self halt at 0x98
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h90);
    doReset();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("pre_halt_pc", fetch_pc, 32'h94);
    checkOutput("pre_halt_halted", 32'(halted), 32'h0);
    tick();
    checkOutput("halt_pc", fetch_pc, 32'h98);
    checkOutput("halt_instr", fetch_instr, 32'h1412FFFF);
    checkOutput("halt_flag", 32'(halted), 32'h1);
    checkOutput("halt_addr", address, 32'h9C);
    checkOutput("halt_fc", 32'(fetched_count), 32'h3);
    tick();
    tick();
    checkOutput("halt_drained", 32'(fetch_valid), 32'h0);
    checkOutput("halt_hold_addr", address, 32'h9C);
    checkOutput("halt_hold_fc", 32'(fetched_count), 32'h3);
    checkOutput("halt_hold_flag", 32'(halted), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    checkOutput("unhalt_flag", 32'(halted), 32'h0);
    checkOutput("unhalt_addr", address, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("resume_pc", fetch_pc, 32'h0);
    checkOutput("resume_fc", 32'(fetched_count), 32'h4);

    // Run off the end of IMEM
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h1F0);
    doReset();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) tick();
    checkOutput("last_pc", fetch_pc, 32'h1FC);
    checkOutput("last_addr", address, 32'h200);
    checkOutput("last_fault", 32'(fault), 32'h0);
    tick();
    checkOutput("fault_flag", 32'(fault), 32'h1);
    checkOutput("fault_valid", 32'(fetch_valid), 32'h0);
    checkOutput("fault_addr", address, 32'h200);
    checkOutput("fault_fc", 32'(fetched_count), 32'h4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    tick();
    checkOutput("fault_redir_flag", 32'(fault), 32'h1);
    checkOutput("fault_redir_addr", address, 32'h200);
    checkOutput("fault_redir_count", 32'(queue_count), 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("fault_reset", 32'(fault), 32'h0);
    reset = 1'b0;

    // Asynchronous reset mid-stream with a full queue and redirect pending
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("pre_async_count", 32'(queue_count), 32'h2);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_count", 32'(queue_count), 32'h0);
    checkOutput("async_valid", 32'(fetch_valid), 32'h0);
    checkOutput("async_addr", address, 32'h0);
    checkOutput("async_pc", fetch_pc, 32'h0);
    checkOutput("async_instr", fetch_instr, 32'h0);
    checkOutput("async_fc", 32'(fetched_count), 32'h0);
    checkOutput("async_halted", 32'(halted), 32'h0);
    checkOutput("async_fault", 32'(fault), 32'h0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/imem_fetch_controller.md
Name: imem_fetch_controller

Overview:
- Sequences the 128-word instruction memory (IMEM).
- Owns the program counter and drives the IMEM word address.
- Buffers fetched {PC, instruction} pairs in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, idles on a branch-to-self halt loop, and faults on out-of-range PCs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WORDS, 128, IMEM depth in words; legal PCs are 0 .. MEM_WORDS*4-4.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  fetch enable; 0 pauses fetch without losing state.
- Address  output  32  IMEM address (= PC); IMEM read is combinational, same cycle.
- Instruction  input  32  IMEM read data for Address.
- FetchValid  output  1  queue head valid.
- FetchReady  input  1  decode accepts head this cycle.
- FetchInstr  output  32  queue head instruction.
- FetchPC  output  32  queue head PC.
- Redirect  input  1  flush and restart at RedirectTarget.
- RedirectTarget  input  32  new PC; bits [1:0] forced to 0.
- Halted  output  1  state HALT.
- Fault  output  1  state FAULT.
- QueueCount  output  2  occupancy, 0..2.
- FetchedCount  output  16  pushes since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, any time, including mid-redirect):
  - PC=RESET_PC, state=FETCH, queue empty.
  - FetchValid=0, FetchInstr=0, FetchPC=0, QueueCount=0.
  - Halted=0, Fault=0, FetchedCount=0.
- Address = PC at all times, combinational from the PC register.
- States: FETCH, HALT, FAULT.
- pop = FetchValid & FetchReady & ~Redirect.
- push = (state==FETCH) & Enable & ~Redirect & PC legal & (QueueCount<2 | pop).
  - On push: enqueue {PC, Instruction}; PC <= PC+4; FetchedCount++ (saturating).
  - Push and pop in the same cycle at QueueCount=2 is legal; count stays 2.
- Queue is FIFO. Head appears on FetchInstr/FetchPC one cycle after its push, so fetch-to-decode latency is 1 cycle.
- Pop with empty queue cannot occur because FetchValid=0.
- Stall (FetchReady=0): queue fills to 2, then PC holds and the head stays stable.
- Enable=0: no push, PC holds, pops still allowed.
- Redirect (highest priority, any state except FAULT):
  - Queue cleared, including the head presented that cycle; that head counts as flushed, not accepted.
  - Next cycle: PC = {RedirectTarget[31:2], 2'b00}, state=FETCH.
  - A target >= MEM_WORDS*4 enters FAULT on the next cycle instead.
- Halt detect:
  - A pushed instruction with opcode[31:26] of 6'b000100 or 6'b000101 and imm[15:0]=16'hFFFF is a branch-to-self.
  - That word is still enqueued; state -> HALT next cycle; PC holds at that word+4.
  - In HALT: no pushes; queue still drains via pops.
  - Exit HALT only on Redirect (to FETCH, or FAULT if the target is illegal) or Reset.
- Range check:
  - In FETCH with Enable=1 and PC >= MEM_WORDS*4: no push; state -> FAULT next cycle.
  - FAULT: no pushes, queue drains normally, Redirect ignored, Fault=1. Exit only by Reset.
- Sequential PC wrap: PC+4 past the last word produces an illegal PC and therefore FAULT. It never aliases to word 0.
- Halted and Fault are registered and asserted the cycle the state is entered.

Test Plan:
- Reset, Enable=1, FetchReady=1, IMEM[i]=i*4 -> FetchValid from cycle 2; FetchPC/FetchInstr = 0/0, 4/4, 8/8 … on consecutive cycles; QueueCount stays 1; FetchedCount increments each cycle.
- FetchReady=0 for 5 cycles after reset -> QueueCount reaches 2 and holds; Address holds at 8; head stays PC 0; release -> PCs 0, 4, 8 delivered in order with no gaps or duplicates.
- Redirect=1, RedirectTarget=32'h0000_0029 while queue holds 2 entries -> next cycle QueueCount=0, Address=32'h28; first delivered FetchPC=32'h28; the flushed head is never accepted.
- IMEM word at PC 32'h98 = 32'h1412FFFF -> entry delivered, then Halted=1, Address holds 32'h9C, FetchedCount frozen; Redirect to 0 -> Halted=0, fetching resumes at 0.
- Fill IMEM with non-branch words, run to PC 32'h1FC -> entry 32'h1FC delivered, Address=32'h200, Fault=1, no further pushes; Redirect ignored; Reset clears Fault.
- Assert Reset mid-stream with QueueCount=2 and Redirect high -> all outputs return to reset values immediately (asynchronously); Address=RESET_PC.
